sigmf_arb: RTL and testbench

SIGMF_ARB -- requirements
Module: sigmf_arb

---
 rtl/sigmf_arb.sv | 137 +++++++++++++
 tb/tb_sigmf_arb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sigmf_arb.sv
// sigmf_arb: round-robin arbiter feeding one shared piecewise-linear sigmoid
// pipeline (signed Q4.20, 0x100000 = 1.0). S1 holds the granted operand and
// tag, and S2 holds the result and tag that drive the outputs.
// Optional build macro SIGMF_ARB_STAT_EN adds the stat_cnt port, which holds
// saturating per-requester accept counters.
module sigmf_arb #(
  parameter int WIDTH = 24,
  parameter int NREQ  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [1:0]              out_tag,
  input  logic                    out_ready
`ifdef SIGMF_ARB_STAT_EN
  ,
  output logic [NREQ*16-1:0]      stat_cnt
`endif
);

  // Q4.20 breakpoints and offsets. 3.2 and 0.8 are not exactly representable,
  // so "|x| > 3.2" becomes "|x| > 0x333333" and "|x| > 0.8" becomes "|x| > 0x0CCCCC".
  localparam logic signed [WIDTH-1:0] TH_SAT  = WIDTH'(32'sh0033_3333);
  localparam logic signed [WIDTH-1:0] TH_MID  = WIDTH'(32'sh000C_CCCC);
  localparam logic signed [WIDTH-1:0] NEG_SAT = -TH_SAT;
  localparam logic signed [WIDTH-1:0] NEG_MID = -TH_MID;
  localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(32'sh0010_0000);
  localparam logic signed [WIDTH-1:0] HALF    = WIDTH'(32'sh0008_0000);
  localparam logic signed [WIDTH-1:0] P4      = WIDTH'(32'sh0006_6666);
  localparam logic signed [WIDTH-1:0] P6      = WIDTH'(32'sh0009_9999);

  logic [1:0]              ptr;
  logic                    s1_valid, s2_valid;
  logic signed [WIDTH-1:0] s1_data;
  logic [1:0]              s1_tag, s2_tag;
  logic [WIDTH-1:0]        s2_data;

  logic                    s2_adv, s1_adv, accept;
  logic                    gnt_any;
  logic [1:0]              gnt_idx;
  logic [WIDTH-1:0]        gnt_data;
  logic signed [WIDTH-1:0] y;

  assign s2_adv = !s2_valid || out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign accept = !rst && s1_adv && gnt_any;

  // Round-robin search: first the requesters at or above ptr, then wrap to those below it.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && req_valid[k] && k >= int'(ptr)) begin
        gnt_any = 1'b1;
        gnt_idx = 2'(k);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && req_valid[k] && k < int'(ptr)) begin
        gnt_any = 1'b1;
        gnt_idx = 2'(k);
      end
    end
  end

  // One-hot grant and operand select for the winning requester.
  always_comb begin
    req_ready = '0;
    gnt_data  = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_ready[k] = accept && (gnt_idx == 2'(k));
      if (gnt_idx == 2'(k)) gnt_data = req_data[k*WIDTH +: WIDTH];
    end
  end

  // Piecewise-linear sigmoid of the S1 operand, using arithmetic shifts and wrapping adds.
  always_comb begin
    if (s1_data > TH_SAT)       y = ONE;
    else if (s1_data < NEG_SAT) y = '0;
    else if (s1_data > TH_MID)  y = (s1_data >>> 3) + P6;
    else if (s1_data < NEG_MID) y = (s1_data >>> 3) + P4;
    else                        y = (s1_data >>> 2) + HALF;
  end

  // Pointer and two-stage pipeline; a stalled stage keeps its contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_tag   <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_tag   <= '0;
    end else begin
      if (accept)
        ptr <= (int'(gnt_idx) == NREQ - 1) ? 2'd0 : gnt_idx + 2'd1;
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_data <= gnt_data;
          s1_tag  <= gnt_idx;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= y;
          s2_tag  <= s1_tag;
        end
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_tag   = s2_tag;

`ifdef SIGMF_ARB_STAT_EN
  // Saturating accept counter per requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cnt <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (req_ready[k] && req_valid[k] && stat_cnt[k*16 +: 16] != 16'hFFFF)
          stat_cnt[k*16 +: 16] <= stat_cnt[k*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sigmf_arb.sv
// Scoreboard bench for sigmf_arb: stimulus pushes hand-computed results,
// and a negedge monitor pops and compares them on each output handshake.
module tb_sigmf_arb;
  localparam int W = 24;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_tag;
  logic           out_ready;
`ifdef SIGMF_ARB_STAT_EN
  logic [N*16-1:0] stat_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [W+1:0] exp_q[$];
  logic [W+1:0] e;

  // Boundary operands and their hand-computed sigmoid values.
  logic [W-1:0] t29_in[10]  = '{24'h400000, 24'hC00000, 24'h333333, 24'h333334, 24'hCCCCCD,
                                24'hCCCCCC, 24'h0CCCCC, 24'h0CCCCD, 24'hF33334, 24'hF33333};
  logic [W-1:0] t29_exp[10] = '{24'h100000, 24'h000000, 24'h0FFFFF, 24'h100000, 24'hFFFFFF,
                                24'h000000, 24'h0B3333, 24'h0B3332, 24'h04CCCD, 24'h04CCCC};
  // Requester k operands {0, 1.0, 0.5} produce {0.5, 0x0B9999, 0x0A0000}.
  logic [W-1:0] rr_in[3]  = '{24'h000000, 24'h100000, 24'h080000};
  logic [W-1:0] rr_exp[3] = '{24'h080000, 24'h0B9999, 24'h0A0000};

  sigmf_arb #(.WIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_ready (out_ready)
`ifdef SIGMF_ARB_STAT_EN
    ,
    .stat_cnt  (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, want);
    end
  endtask

  task automatic push(input logic [1:0] tag, input logic [W-1:0] d);
    exp_q.push_back({tag, d});
  endtask

  task automatic set_op(input int k, input logic [W-1:0] v);
    req_data[k*W +: W] = v;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  // Monitor: the handshake completes on the next posedge, so compare at this negedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got data=%0h tag=%0d, required no output", out_data, out_tag);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e[W-1:0]));
        chk("out_tag", 32'(out_tag), 32'(e[W+1:W]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b1;
    drive_edge();
    req_valid = 3'b111;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    drive_edge();
    rst = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 0);

    // Single operand from requester 0; result visible after the edge following the accept edge.
    drive_edge();
    req_valid = 3'b001; set_op(0, 24'h000000);
    @(negedge clk);
    chk("t27_ready", 32'(req_ready), 32'h1);
    push(2'd0, 24'h080000);
    drive_edge();
    req_valid = '0;
    @(negedge clk);
    chk("t27_s1_only", 32'(out_valid), 0);
    drive_edge();
    @(negedge clk);
    chk("t27_out_valid", 32'(out_valid), 1);

    // Back-to-back operands from requester 1.
    drive_edge();
    req_valid = 3'b010; set_op(1, 24'h100000);
    @(negedge clk);
    chk("t28_ready0", 32'(req_ready), 32'h2);
    push(2'd1, 24'h0B9999);
    drive_edge();
    set_op(1, 24'h080000);
    @(negedge clk);
    chk("t28_ready1", 32'(req_ready), 32'h2);
    push(2'd1, 24'h0A0000);
    drive_edge();
    req_valid = '0;
    @(negedge clk);
    chk("t28_first", 32'(out_data), 32'h0B9999);
    drive_edge();
    @(negedge clk);
    chk("t28_second_valid", 32'(out_valid), 1);
    chk("t28_second", 32'(out_data), 32'h0A0000);

    // Saturation and breakpoint vectors streamed from requester 2.
    for (int i = 0; i < 10; i++) begin
      drive_edge();
      req_valid = 3'b100; set_op(2, t29_in[i]);
      @(negedge clk);
      chk("t29_ready", 32'(req_ready), 32'h4);
      push(2'd2, t29_exp[i]);
    end
    drive_edge();
    req_valid = '0;
    drain("t29_drain");

    // All requesters valid: grants rotate 0,1,2,0,1,2.
    for (int k = 0; k < N; k++) set_op(k, rr_in[k]);
    for (int i = 0; i < 6; i++) begin
      drive_edge();
      req_valid = 3'b111;
      @(negedge clk);
      chk("t30_grant", 32'(req_ready), 32'(1 << (i % 3)));
      push(2'(i % 3), rr_exp[i % 3]);
    end
    drive_edge();
    req_valid = '0;
    drain("t30_drain");

    // Backpressure: two accepts fill the pipe, then the grant stops and the output holds.
    drive_edge();
    out_ready = 1'b0; req_valid = 3'b111;
    @(negedge clk);
    chk("t31_ready0", 32'(req_ready), 32'h1);
    push(2'd0, rr_exp[0]);
    drive_edge();
    @(negedge clk);
    chk("t31_ready1", 32'(req_ready), 32'h2);
    push(2'd1, rr_exp[1]);
    for (int i = 0; i < 3; i++) begin
      drive_edge();
      @(negedge clk);
      chk("t31_stall_ready", 32'(req_ready), 0);
      chk("t31_hold_valid", 32'(out_valid), 1);
      chk("t31_hold_data", 32'(out_data), 32'h080000);
    end
    for (int i = 0; i < 3; i++) begin
      drive_edge();
      out_ready = 1'b1;
      @(negedge clk);
      chk("t31_resume", 32'(req_ready), 32'(1 << ((i + 2) % 3)));
      push(2'((i + 2) % 3), rr_exp[(i + 2) % 3]);
    end
    drive_edge();
    req_valid = '0;
    drain("t31_drain");

    // Reset with both stages full: in-flight data is dropped and the pointer returns to 0.
    drive_edge();
    out_ready = 1'b0; req_valid = 3'b010;
    @(negedge clk);
    chk("t32_fill0", 32'(req_ready), 32'h2);
    drive_edge();
    @(negedge clk);
    chk("t32_fill1", 32'(req_ready), 32'h2);
    drive_edge();
    rst = 1'b1; req_valid = 3'b111;
    @(negedge clk);
    chk("t32_rst_ready", 32'(req_ready), 0);
    drive_edge();
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("t32_out_valid", 32'(out_valid), 0);
    chk("t32_first_grant", 32'(req_ready), 32'h1);
`ifdef SIGMF_ARB_STAT_EN
    chk("t32_stat_clear", 32'(stat_cnt), 0);
`endif
    push(2'd0, rr_exp[0]);
    drive_edge();
    req_valid = '0;
    drain("t32_drain");
`ifdef SIGMF_ARB_STAT_EN
    chk("stat_req0", 32'(stat_cnt[15:0]), 1);
    chk("stat_req12", 32'(stat_cnt[47:16]), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
